// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci result collector: default sizes,
// controller state encoding, result entry layout and a saturating counter helper.
package fib_pkg;

  localparam int FIB_W     = 11;
  localparam int FIB_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  // One buffered result: loop bound and the sum the engine reported with it.
  typedef struct packed {
    logic [FIB_W-1:0] n;
    logic [FIB_W-1:0] sum;
  } entry_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/fib_result_fifo.sv
// Result FIFO: DEPTH entries of EW bits, wrapping pointers and an occupancy
// counter so full and empty stay distinct. A push into a full FIFO is taken
// only when a pop happens on the same edge; otherwise the caller drops it.
module fib_result_fifo #(
  parameter int EW    = 22,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [EW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [EW-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // When full, the slot being written is the head being popped on this same
  // edge, so the old head is consumed before it is overwritten.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fib_result_collector.sv
// Watches a Fibonacci engine's loop index and bound, captures {n, sum} once per
// completion into a small FIFO, and tracks accepted results and drops.
module fib_result_collector
  import fib_pkg::*;
#(
  parameter int W     = FIB_W,
  parameter int DEPTH = FIB_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_in,
  input  logic [W-1:0] n_in,
  input  logic [W-1:0] sum_in,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_n,
  output logic [W-1:0] out_sum,
  output logic         overflow,
  output logic [7:0]   result_count,
  output logic         busy
);

  state_t         state;
  state_t         next_state;
  logic           done;
  logic           push;
  logic           pop;
  logic           full;
  logic           empty;
  logic           accepted;
  logic           dropped;
  logic [2*W-1:0] head;

  assign done = (i_in == n_in);

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and push: only BUSY captures, so a completion seen straight out
  // of reset or held for several cycles never produces a second entry.
  always_comb begin
    next_state = state;
    push       = 1'b0;
    case (state)
      IDLE: if (!done) next_state = BUSY;
      BUSY: if (done) begin
        push       = 1'b1;
        next_state = HOLD;
      end
      HOLD: if (!done) next_state = BUSY;
      default: next_state = IDLE;
    endcase
  end

  assign pop      = !empty && out_ready;
  assign accepted = push && (!full || pop);
  assign dropped  = push && full && !pop;

  fib_result_fifo #(
    .EW    (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({n_in, sum_in}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Sticky drop flag and saturating count of results that made it into the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow     <= 1'b0;
      result_count <= 8'd0;
    end else begin
      if (dropped)  overflow     <= 1'b1;
      if (accepted) result_count <= sat_inc8(result_count);
    end
  end

  assign out_valid = !empty;
  assign out_n     = empty ? '0 : head[2*W-1:W];
  assign out_sum   = empty ? '0 : head[W-1:0];
  assign busy      = (state == BUSY);

endmodule

// File: tb/tb_fib_result_collector.sv
// Bench for fib_result_collector: a directed vector table, hand-written
// full/overflow/reset sequences, and a randomized run against a queue model.
module tb_fib_result_collector;
  import fib_pkg::*;

  localparam int W     = FIB_W;
  localparam int DEPTH = FIB_DEPTH;

  logic         clk;
  logic         rst;
  logic [W-1:0] i_in;
  logic [W-1:0] n_in;
  logic [W-1:0] sum_in;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_n;
  logic [W-1:0] out_sum;
  logic         overflow;
  logic [7:0]   result_count;
  logic         busy;

  int vectors     = 0;
  int miscompares = 0;

  fib_result_collector #(.W(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_in         (i_in),
    .n_in         (n_in),
    .sum_in       (sum_in),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_n        (out_n),
    .out_sum      (out_sum),
    .overflow     (overflow),
    .result_count (result_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    int   i;
    int   n;
    int   s;
    logic rdy;
    logic ev;
    int   en;
    int   es;
    logic eo;
    int   ec;
    logic eb;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic r, int i, int n, int s, logic rdy,
                              logic ev, int en, int es, logic eo, int ec, logic eb);
    vec_t v;
    v.rst = r; v.i = i; v.n = n; v.s = s; v.rdy = rdy;
    v.ev = ev; v.en = en; v.es = es; v.eo = eo; v.ec = ec; v.eb = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and sample just after the rising edge.
  task automatic step(input logic r, input int i, input int n, input int s, input logic rdy);
    rst       = r;
    i_in      = W'(i);
    n_in      = W'(n);
    sum_in    = W'(s);
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic complete(input int k, input int s, input logic rdy);
    step(1'b0, 0, k, 0, rdy);
    step(1'b0, k, k, s, rdy);
  endtask

  // Randomized-phase reference state.
  entry_t   q[$];
  logic     armed;
  logic     m_ovf;
  int       m_cnt;

  task automatic rand_cycle(input logic r, input int rdy_pct);
    int   i, n, s;
    logic rdy, done, do_pop;
    i    = $urandom_range(0, 2);
    n    = $urandom_range(0, 2);
    s    = $urandom_range(0, 2047);
    rdy  = ($urandom_range(0, 99) < rdy_pct);
    done = (i == n);
    do_pop = (q.size() > 0) && rdy;
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
      m_cnt = 0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (armed && done) begin
        if (q.size() < DEPTH) begin
          entry_t e;
          e.n = W'(n);
          e.sum = W'(s);
          q.push_back(e);
          if (m_cnt < 255) m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    // A capture needs a not-done cycle since the last capture or reset.
    armed = !r && !done;
    step(r, i, n, s, rdy);
    check("rnd_valid", out_valid, (q.size() > 0));
    if (q.size() > 0) begin
      check("rnd_n", out_n, q[0].n);
      check("rnd_sum", out_sum, q[0].sum);
    end
    check("rnd_ovf", overflow, m_ovf);
    check("rnd_count", result_count, m_cnt);
    check("rnd_busy", busy, armed);
  endtask

  initial begin
    rst = 1'b1; i_in = '0; n_in = '0; sum_in = '0; out_ready = 1'b0;

    // Reset hold, single completion, then a held completion.
    for (int k = 0; k < 5; k++) tbl[k] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 1);
    tbl[7]  = mk(0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 1);
    tbl[8]  = mk(0, 2, 5, 2, 1, 0, 0, 0, 0, 0, 1);
    tbl[9]  = mk(0, 3, 5, 4, 1, 0, 0, 0, 0, 0, 1);
    tbl[10] = mk(0, 4, 5, 7, 1, 0, 0, 0, 0, 0, 1);
    tbl[11] = mk(0, 5, 5, 8, 1, 1, 5, 8, 0, 1, 0);
    for (int k = 12; k < 22; k++) tbl[k] = mk(0, 5, 5, 8, 0, 1, 5, 8, 0, 1, 0);
    tbl[22] = mk(0, 5, 5, 8, 1, 0, 0, 0, 0, 1, 0);

    for (int k = 0; k < 23; k++) begin
      step(tbl[k].rst, tbl[k].i, tbl[k].n, tbl[k].s, tbl[k].rdy);
      check($sformatf("tbl%0d_valid", k), out_valid, tbl[k].ev);
      if (tbl[k].ev) begin
        check($sformatf("tbl%0d_n", k), out_n, tbl[k].en);
        check($sformatf("tbl%0d_sum", k), out_sum, tbl[k].es);
      end
      check($sformatf("tbl%0d_ovf", k), overflow, tbl[k].eo);
      check($sformatf("tbl%0d_count", k), result_count, tbl[k].ec);
      check($sformatf("tbl%0d_busy", k), busy, tbl[k].eb);
      if (tbl[k].rst) begin
        check($sformatf("tbl%0d_rst_n", k), out_n, 0);
        check($sformatf("tbl%0d_rst_sum", k), out_sum, 0);
      end
    end

    // Five completions with the consumer stalled: fifth is dropped.
    step(1'b1, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) complete(k, k * 10, 1'b0);
    check("ovf_valid", out_valid, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_count", result_count, 4);
    for (int k = 1; k <= 4; k++) begin
      check("ovf_drain_n", out_n, k);
      check("ovf_drain_sum", out_sum, k * 10);
      step(1'b0, 0, 1, 0, 1'b1);
    end
    check("ovf_empty", out_valid, 0);
    check("ovf_sticky", overflow, 1);

    // Full FIFO, completion lands on the same edge as a pop.
    step(1'b1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) complete(k, k + 100, 1'b0);
    check("fullpop_count4", result_count, 4);
    step(1'b0, 0, 5, 0, 1'b0);
    step(1'b0, 5, 5, 105, 1'b1);
    check("fullpop_ovf", overflow, 0);
    check("fullpop_count", result_count, 5);
    for (int k = 2; k <= 5; k++) begin
      check("fullpop_order_n", out_n, k);
      check("fullpop_order_sum", out_sum, k + 100);
      step(1'b0, 0, 1, 0, 1'b1);
    end
    check("fullpop_empty", out_valid, 0);

    // Reset mid-operation with three entries buffered and a coincident completion.
    step(1'b1, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) complete(k, k, 1'b0);
    step(1'b0, 0, 7, 0, 1'b0);
    check("midrst_busy_before", busy, 1);
    step(1'b1, 7, 7, 70, 1'b0);
    check("midrst_valid", out_valid, 0);
    check("midrst_ovf", overflow, 0);
    check("midrst_count", result_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_n", out_n, 0);
    check("midrst_sum", out_sum, 0);
    step(1'b0, 7, 7, 70, 1'b1);
    check("postrst_valid", out_valid, 0);
    check("postrst_busy", busy, 0);
    check("postrst_count", result_count, 0);

    // Randomized run: high drain rate (reaches count saturation), then stalls and resets.
    rand_cycle(1'b1, 100);
    for (int c = 0; c < 2000; c++) rand_cycle(1'b0, 95);
    check("rnd_saturated", result_count, 255);
    for (int c = 0; c < 2000; c++) rand_cycle(($urandom_range(0, 199) == 0), 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fib_result_collector.md
FIB_RESULT_COLLECTOR -- requirements
Module: fib_result_collector

Interface
REQ-001 Parameter W, default 11, data width of upstream index/bound/sum buses.
REQ-002 Parameter DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_in  input  W  upstream loop index (fib engine output i).
REQ-006 n_in  input  W  upstream loop bound (fib engine output n).
REQ-007 sum_in  input  W  upstream running sum (fib engine output sum).
REQ-008 out_ready  input  1  downstream accepts head entry this cycle.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_n  output  W  bound of head result.
REQ-011 out_sum  output  W  sum of head result.
REQ-012 overflow  output  1  sticky: a completed result was dropped.
REQ-013 result_count  output  8  accepted results, saturating.
REQ-014 busy  output  1  high while in state BUSY.

Function
REQ-015 Completion condition: done = (i_in == n_in), sampled every cycle.
REQ-016 States IDLE, BUSY, HOLD; reset enters IDLE.
REQ-017 IDLE: done=0 -> BUSY; done=1 -> stay IDLE, no capture (reset-time values never captured).
REQ-018 BUSY: done=1 -> push {n_in, sum_in} same edge, go HOLD; done=0 -> stay.
REQ-019 HOLD: done=0 -> BUSY; done=1 -> stay, no further push (one push per completion).
REQ-020 Push latency: entry visible on out_valid/out_n/out_sum one cycle after the completion edge.
REQ-021 out_valid = FIFO non-empty; out_n/out_sum = head entry, stable while out_valid=1 and out_ready=0.
REQ-022 Pop when out_valid && out_ready; out_ready ignored when empty.
REQ-023 Push when full with simultaneous pop: push accepted, occupancy unchanged, order preserved.
REQ-024 Push when full without pop: entry dropped, overflow set, result_count unchanged.
REQ-025 overflow remains 1 until rst.
REQ-026 result_count increments by 1 per accepted push; holds at 255.
REQ-027 Pointers wrap modulo DEPTH; occupancy counter 0..DEPTH distinguishes full/empty.
REQ-028 Data captured verbatim, no arithmetic on sum_in/n_in.

Reset
REQ-029 rst=1 at a clock edge: state=IDLE, FIFO emptied, out_valid=0, out_n=0, out_sum=0, overflow=0, result_count=0, busy=0.
REQ-030 rst mid-operation discards all buffered entries and any coincident push; no pop is reported.
REQ-031 First cycle after rst deassertion behaves per IDLE rules.

Structure
REQ-032 Shared package fib_pkg holds W, DEPTH defaults, the state enum, and the {n,sum} entry typedef.
REQ-033 FIFO storage/pointers are a sub-module fib_result_fifo (push, pop, full, empty, head); FSM and counters in top.

Verification
REQ-034 Reset with i_in=n_in=0 held 5 cycles -> out_valid=0, result_count=0, state stays IDLE.
REQ-035 i_in 0..5 with n_in=5, sum_in=8 at i_in=5, out_ready=1 -> one entry out_n=5, out_sum=8 one cycle after, result_count=1.
REQ-036 Hold i_in=n_in=5 for 10 cycles after completion -> exactly one push, result_count=1.
REQ-037 out_ready=0, five completions (n=1..5) -> entries n=1..4 held, overflow=1, result_count=4; then out_ready=1 -> n=1,2,3,4 in order, then out_valid=0.
REQ-038 FIFO full, completion coincides with pop -> push accepted, overflow stays 0, order preserved.
REQ-039 rst asserted with 3 entries buffered and BUSY -> next cycle out_valid=0, overflow=0, result_count=0, IDLE.
